// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide sequencer.
// Optional build macro used by the controller: MULDIV_EARLY_OUT_EN.
package muldiv_pkg;

    localparam int MD_XLEN = 32;

    // Operation codes presented by the execute stage; 6 and 7 are reserved.
    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } muldiv_op_t;

    // Sequencer states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIX  = 2'd3
    } muldiv_state_t;

    // Iteration kind performed by the step datapath.
    localparam logic STEP_MUL = 1'b0;
    localparam logic STEP_DIV = 1'b1;

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration of the multiply/divide datapath.
// Multiply: radix-2 shift-add on {partial_product, remaining_multiplier}.
// Divide: restoring shift-subtract on {remainder, quotient}.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int XLEN = MD_XLEN
) (
    input  logic              mode,
    input  logic [2*XLEN-1:0] acc_in,
    input  logic [XLEN-1:0]   operand,
    output logic [2*XLEN-1:0] acc_out
);

    logic [XLEN:0]   mul_sum_s;
    logic [XLEN:0]   rem_sh_s;
    logic [XLEN-1:0] div_diff_s;
    logic            div_ge_s;

    // Compute both candidate iterations and select the one for this mode.
    always_comb begin
        // Add the multiplicand when the current multiplier LSB is set; carry is kept.
        if (acc_in[0]) begin
            mul_sum_s = {1'b0, acc_in[2*XLEN-1:XLEN]} + {1'b0, operand};
        end else begin
            mul_sum_s = {1'b0, acc_in[2*XLEN-1:XLEN]};
        end

        // Shift the next dividend bit into the partial remainder and trial-subtract.
        rem_sh_s   = acc_in[2*XLEN-1:XLEN-1];
        div_ge_s   = (rem_sh_s >= {1'b0, operand});
        div_diff_s = rem_sh_s[XLEN-1:0] - operand;

        if (mode == STEP_DIV) begin
            if (div_ge_s) begin
                acc_out = {div_diff_s, acc_in[XLEN-2:0], 1'b1};
            end else begin
                acc_out = {rem_sh_s[XLEN-1:0], acc_in[XLEN-2:0], 1'b0};
            end
        end else begin
            acc_out = {mul_sum_s, acc_in[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// Multi-cycle multiply/divide sequencer owning the HI/LO registers.
// Signed operations run on magnitudes; signs are reapplied in FIX.
// Build option MULDIV_EARLY_OUT_EN: multiply exits once the remaining
// multiplier bits are zero, and divide-by-zero skips the iterations.
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int XLEN = MD_XLEN
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            mf_req,
    input  logic            abort,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo,
    output logic            busy,
    output logic            done,
    output logic            stall
);

    localparam int                CW       = $clog2(XLEN);
    localparam logic [CW-1:0]     CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0]     CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]     CNT_LAST = CW'(XLEN-1);
    localparam logic [XLEN-1:0]   X_ZERO   = {XLEN{1'b0}};
    localparam logic [XLEN-1:0]   X_ONES   = {XLEN{1'b1}};
    localparam logic [XLEN-1:0]   X_ONE    = {{(XLEN-1){1'b0}}, 1'b1};
    localparam logic [2*XLEN-1:0] W_ONE    = {{(2*XLEN-1){1'b0}}, 1'b1};

    function automatic logic [XLEN-1:0] neg_x(input logic [XLEN-1:0] v);
        neg_x = (~v) + X_ONE;
    endfunction

    function automatic logic [XLEN-1:0] abs_x(input logic [XLEN-1:0] v, input logic sgn);
        if (sgn && v[XLEN-1]) begin
            abs_x = neg_x(v);
        end else begin
            abs_x = v;
        end
    endfunction

    muldiv_state_t     state_r, state_nx_s;
    muldiv_op_t        op_s;
    logic [CW-1:0]     counter_r;
    logic [2*XLEN-1:0] acc_r;
    logic [XLEN-1:0]   opnd_r;
    logic [XLEN-1:0]   dividend_r;
    logic              neg_q_r;
    logic              neg_r_r;
    logic              dz_r;
    logic              is_div_r;
    logic [XLEN-1:0]   hi_r, lo_r;
    logic              busy_r, done_r;
    logic [XLEN-1:0]   hi_nx_s, lo_nx_s;
    logic [2*XLEN-1:0] step_out_s;
    logic              step_mode_s;
    logic              accept_s;
    logic              signed_s;
    logic              b_zero_s;
    logic              mul_exit_s;
    logic [XLEN-1:0]   abs_a_s, abs_b_s;
    logic [2*XLEN-1:0] fix_acc_s;
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   quot_s, rem_s;

    assign op_s = muldiv_op_t'(op);

    muldiv_step #(.XLEN(XLEN)) u_step (
        .mode    (step_mode_s),
        .acc_in  (acc_r),
        .operand (opnd_r),
        .acc_out (step_out_s)
    );

    // Decode the incoming request and operand magnitudes.
    always_comb begin
        accept_s    = (state_r == IDLE) && start && !abort;
        signed_s    = (op_s == MD_MULT) || (op_s == MD_DIV);
        b_zero_s    = (b == X_ZERO);
        abs_a_s     = abs_x(a, signed_s);
        abs_b_s     = abs_x(b, signed_s);
        step_mode_s = (state_r == DIV) ? STEP_DIV : STEP_MUL;
    end

    // Decide when the multiply loop can leave for FIX.
    always_comb begin
`ifdef MULDIV_EARLY_OUT_EN
        // Low counter_r bits of the stepped accumulator are the multiplier bits still unconsumed.
        if (counter_r == CNT_ZERO) begin
            mul_exit_s = 1'b1;
        end else begin
            mul_exit_s = ((step_out_s[XLEN-1:0] & ~(X_ONES << counter_r)) == X_ZERO);
        end
`else
        mul_exit_s = (counter_r == CNT_ZERO);
`endif
    end

    // State register plus registered busy/done derived from the next state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            busy_r  <= (state_nx_s != IDLE);
            done_r  <= (state_nx_s == FIX);
        end
    end

    // Next-state logic; abort returns to IDLE from any state.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    case (op_s)
                        MD_MULT, MD_MULTU: state_nx_s = MUL;
`ifdef MULDIV_EARLY_OUT_EN
                        MD_DIV, MD_DIVU:   state_nx_s = b_zero_s ? FIX : DIV;
`else
                        MD_DIV, MD_DIVU:   state_nx_s = DIV;
`endif
                        default:           state_nx_s = IDLE;
                    endcase
                end else begin
                    state_nx_s = IDLE;
                end
            end
            MUL: begin
                if (abort) begin
                    state_nx_s = IDLE;
                end else if (mul_exit_s) begin
                    state_nx_s = FIX;
                end else begin
                    state_nx_s = MUL;
                end
            end
            DIV: begin
                if (abort) begin
                    state_nx_s = IDLE;
                end else if (counter_r == CNT_ZERO) begin
                    state_nx_s = FIX;
                end else begin
                    state_nx_s = DIV;
                end
            end
            FIX:     state_nx_s = IDLE;
            default: state_nx_s = IDLE;
        endcase
    end

    // Iteration datapath: operand/sign latching at accept, one step per busy cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            counter_r  <= CNT_ZERO;
            acc_r      <= {(2*XLEN){1'b0}};
            opnd_r     <= X_ZERO;
            dividend_r <= X_ZERO;
            neg_q_r    <= 1'b0;
            neg_r_r    <= 1'b0;
            dz_r       <= 1'b0;
            is_div_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s && (op_s == MD_MULT || op_s == MD_MULTU)) begin
                        acc_r     <= {X_ZERO, abs_b_s};
                        opnd_r    <= abs_a_s;
                        counter_r <= CNT_LAST;
                        neg_q_r   <= signed_s && (a[XLEN-1] ^ b[XLEN-1]);
                        neg_r_r   <= 1'b0;
                        dz_r      <= 1'b0;
                        is_div_r  <= 1'b0;
                    end else if (accept_s && (op_s == MD_DIV || op_s == MD_DIVU)) begin
                        acc_r      <= {X_ZERO, abs_a_s};
                        opnd_r     <= abs_b_s;
                        dividend_r <= a;
                        counter_r  <= CNT_LAST;
                        neg_q_r    <= signed_s && (a[XLEN-1] ^ b[XLEN-1]);
                        neg_r_r    <= signed_s && a[XLEN-1];
                        dz_r       <= b_zero_s;
                        is_div_r   <= 1'b1;
                    end else begin
                        acc_r <= acc_r;
                    end
                end
                MUL: begin
                    acc_r <= step_out_s;
                    // On exit the counter keeps the number of shifts still owed to FIX.
                    if (!mul_exit_s) begin
                        counter_r <= counter_r - CNT_ONE;
                    end else begin
                        counter_r <= counter_r;
                    end
                end
                DIV: begin
                    acc_r <= step_out_s;
                    if (counter_r != CNT_ZERO) begin
                        counter_r <= counter_r - CNT_ONE;
                    end else begin
                        counter_r <= counter_r;
                    end
                end
                default: begin
                    acc_r <= acc_r;
                end
            endcase
        end
    end

    // Final alignment and sign correction of the accumulated result.
    always_comb begin
`ifdef MULDIV_EARLY_OUT_EN
        fix_acc_s = is_div_r ? acc_r : (acc_r >> counter_r);
`else
        fix_acc_s = acc_r;
`endif
        if (neg_q_r) begin
            prod_s = (~fix_acc_s) + W_ONE;
        end else begin
            prod_s = fix_acc_s;
        end
        quot_s = neg_q_r ? neg_x(fix_acc_s[XLEN-1:0]) : fix_acc_s[XLEN-1:0];
        rem_s  = neg_r_r ? neg_x(fix_acc_s[2*XLEN-1:XLEN]) : fix_acc_s[2*XLEN-1:XLEN];
    end

    // Output logic: next HI/LO from MT writes in IDLE or the result commit in FIX.
    always_comb begin
        hi_nx_s = hi_r;
        lo_nx_s = lo_r;
        case (state_r)
            IDLE: begin
                if (accept_s && op_s == MD_MTHI) begin
                    hi_nx_s = a;
                end else if (accept_s && op_s == MD_MTLO) begin
                    lo_nx_s = a;
                end else begin
                    hi_nx_s = hi_r;
                    lo_nx_s = lo_r;
                end
            end
            FIX: begin
                if (abort) begin
                    hi_nx_s = hi_r;
                    lo_nx_s = lo_r;
                end else if (is_div_r && dz_r) begin
                    hi_nx_s = dividend_r;
                    lo_nx_s = X_ONES;
                end else if (is_div_r) begin
                    hi_nx_s = rem_s;
                    lo_nx_s = quot_s;
                end else begin
                    hi_nx_s = prod_s[2*XLEN-1:XLEN];
                    lo_nx_s = prod_s[XLEN-1:0];
                end
            end
            default: begin
                hi_nx_s = hi_r;
                lo_nx_s = lo_r;
            end
        endcase
    end

    // Architectural HI/LO registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            hi_r <= X_ZERO;
            lo_r <= X_ZERO;
        end else begin
            hi_r <= hi_nx_s;
            lo_r <= lo_nx_s;
        end
    end

    assign hi    = hi_r;
    assign lo    = lo_r;
    assign busy  = busy_r;
    assign done  = done_r;
    assign stall = busy_r & (start | mf_req);

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: arithmetic reference model with a
// per-cycle compare process, plus directed literal expectations.
module tb_muldiv_ctrl;
    import muldiv_pkg::*;

`ifdef MULDIV_EARLY_OUT_EN
    localparam bit EO = 1'b1;
`else
    localparam bit EO = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        mf_req = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] hi, lo;
    logic        busy, done, stall;

    int checks = 0;
    int failures = 0;
    int busy_cnt = 0;
    int done_cnt = 0;
    bit chk_on = 1'b0;

    // Reference model state
    logic [31:0] m_hi = 32'd0, m_lo = 32'd0, p_hi = 32'd0, p_lo = 32'd0;
    bit          m_busy = 1'b0;
    int          m_cnt = 0;

    muldiv_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .mf_req(mf_req), .abort(abort), .hi(hi), .lo(lo),
        .busy(busy), .done(done), .stall(stall)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic int mul_latency(input logic [31:0] mb);
        int k;
        k = 1;
        for (int i = 0; i < 32; i++) if (mb[i]) k = i + 1;
        return EO ? (k + 1) : 33;
    endfunction

    // Reference model: results from plain arithmetic, timing from a latency count.
    always @(posedge clk) begin
        logic [63:0] up;
        longint      sp;
        int          sa, sb;
        logic [31:0] mb;
        if (!reset) begin
            m_hi = 32'd0; m_lo = 32'd0; m_busy = 1'b0; m_cnt = 0;
        end else if (m_busy) begin
            if (abort) m_busy = 1'b0;
            else if (m_cnt == 1) begin
                m_hi = p_hi; m_lo = p_lo; m_busy = 1'b0;
            end else m_cnt--;
        end else if (start && !abort) begin
            case (op)
                3'd0, 3'd1: begin
                    if (op == 3'd0) begin
                        sp = longint'($signed(a)) * longint'($signed(b));
                        up = sp;
                        mb = b[31] ? (32'd0 - b) : b;
                    end else begin
                        up = {32'd0, a} * {32'd0, b};
                        mb = b;
                    end
                    p_hi = up[63:32]; p_lo = up[31:0];
                    m_cnt = mul_latency(mb); m_busy = 1'b1;
                end
                3'd2, 3'd3: begin
                    if (b == 32'd0) begin
                        p_lo = 32'hFFFF_FFFF; p_hi = a;
                    end else if (op == 3'd2 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                        p_lo = 32'h8000_0000; p_hi = 32'd0;
                    end else if (op == 3'd2) begin
                        sa = $signed(a); sb = $signed(b);
                        p_lo = sa / sb; p_hi = sa % sb;
                    end else begin
                        p_lo = a / b; p_hi = a % b;
                    end
                    m_cnt = (EO && b == 32'd0) ? 1 : 33; m_busy = 1'b1;
                end
                3'd4: m_hi = a;
                3'd5: m_lo = a;
                default: ;
            endcase
        end
    end

    // Per-cycle comparison against the model, sampled on the falling edge.
    always @(negedge clk) begin
        if (busy === 1'b1) busy_cnt++;
        if (done === 1'b1) done_cnt++;
        if (chk_on) begin
            check("cyc_hi", {32'd0, hi}, {32'd0, m_hi});
            check("cyc_lo", {32'd0, lo}, {32'd0, m_lo});
            check("cyc_busy", {63'd0, busy}, {63'd0, m_busy});
            check("cyc_done", {63'd0, done}, {63'd0, (m_busy && m_cnt == 1)});
            check("cyc_stall", {63'd0, stall}, {63'd0, (m_busy && (start || mf_req))});
        end
    end

    task automatic start_op(input logic [2:0] o, input logic [31:0] va, input logic [31:0] vb);
        @(posedge clk); #1;
        start = 1'b1; op = o; a = va; b = vb;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", {63'd0, busy}, 64'd0);
    endtask

    initial begin
        int bc0, dc0;
        // Global bound so the run can never hang.
        fork
            begin
                #2000000;
                $display("FAIL global_timeout");
                $fatal(1);
            end
        join_none

        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        chk_on = 1'b1;
        @(negedge clk);
        check("rst_hi", {32'd0, hi}, 64'd0);
        check("rst_lo", {32'd0, lo}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);

        // MULTU 7*6
        bc0 = busy_cnt; dc0 = done_cnt;
        start_op(MD_MULTU, 32'd7, 32'd6);
        wait_idle();
        check("multu_busy_cycles", 64'(busy_cnt - bc0), EO ? 64'd4 : 64'd33);
        check("multu_done_pulses", 64'(done_cnt - dc0), 64'd1);
        check("multu_hi", {32'd0, hi}, 64'd0);
        check("multu_lo", {32'd0, lo}, 64'd42);

        // MULT -3*5, then DIV -7/2
        start_op(MD_MULT, 32'hFFFF_FFFD, 32'd5);
        wait_idle();
        check("mult_hi", {32'd0, hi}, 64'h0000_0000_FFFF_FFFF);
        check("mult_lo", {32'd0, lo}, 64'h0000_0000_FFFF_FFF1);
        start_op(MD_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_idle();
        check("div_lo", {32'd0, lo}, 64'h0000_0000_FFFF_FFFD);
        check("div_hi", {32'd0, hi}, 64'h0000_0000_FFFF_FFFF);

        // Divide by zero and signed overflow
        bc0 = busy_cnt;
        start_op(MD_DIVU, 32'd100, 32'd0);
        wait_idle();
        check("dz_busy_cycles", 64'(busy_cnt - bc0), EO ? 64'd1 : 64'd33);
        check("dz_lo", {32'd0, lo}, 64'h0000_0000_FFFF_FFFF);
        check("dz_hi", {32'd0, hi}, 64'h64);
        start_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle();
        check("ovf_lo", {32'd0, lo}, 64'h0000_0000_8000_0000);
        check("ovf_hi", {32'd0, hi}, 64'd0);
        start_op(MD_DIV, 32'hFFFF_FFF9, 32'd0);
        wait_idle();
        check("sdz_hi", {32'd0, hi}, 64'h0000_0000_FFFF_FFF9);

        // Back-to-back MTHI / MTLO
        bc0 = busy_cnt;
        @(posedge clk); #1;
        start = 1'b1; op = MD_MTHI; a = 32'h1234;
        @(posedge clk); #1;
        op = MD_MTLO; a = 32'h5678;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("mt_hi", {32'd0, hi}, 64'h1234);
        check("mt_lo", {32'd0, lo}, 64'h5678);
        check("mt_busy_cycles", 64'(busy_cnt - bc0), 64'd0);

        // MT blocked by abort
        @(posedge clk); #1;
        start = 1'b1; op = MD_MTHI; a = 32'hDEAD; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        @(negedge clk);
        check("mt_abort_hi", {32'd0, hi}, 64'h1234);

        // MULT 3*3 with mf_req at cycle 10
        start_op(MD_MULT, 32'd3, 32'd3);
        repeat (9) @(posedge clk);
        #1 mf_req = 1'b1;
        @(negedge clk);
        check("mf_stall_busy", {63'd0, stall}, EO ? 64'd0 : 64'd1);
        wait_idle();
        check("mf_stall_after", {63'd0, stall}, 64'd0);
        #1 mf_req = 1'b0;
        check("mf_lo", {32'd0, lo}, 64'd9);

        // MULT 2*2 aborted at cycle 5
        dc0 = done_cnt;
        start_op(MD_MULT, 32'd2, 32'd2);
        repeat (4) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        @(negedge clk);
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_done", 64'(done_cnt - dc0), EO ? 64'd1 : 64'd0);
        check("abort_hi", {32'd0, hi}, 64'd0);
        check("abort_lo", {32'd0, lo}, EO ? 64'd4 : 64'd9);

        // Start held while busy: accepted in the first IDLE cycle after FIX
        dc0 = done_cnt;
        start_op(MD_MULTU, 32'd7, 32'd6);
        start = 1'b1; op = MD_DIVU; a = 32'd100; b = 32'd7;
        wait_idle();
        @(posedge clk); #1 start = 1'b0;
        wait_idle();
        check("chain_hi", {32'd0, hi}, 64'd2);
        check("chain_lo", {32'd0, lo}, 64'd14);
        check("chain_done", 64'(done_cnt - dc0), 64'd2);

        // Reset in the middle of a divide
        start_op(MD_DIVU, 32'd1000, 32'd3);
        repeat (14) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        check("midrst_hi", {32'd0, hi}, 64'd0);
        check("midrst_lo", {32'd0, lo}, 64'd0);
        check("midrst_busy", {63'd0, busy}, 64'd0);

        // MULTU 5*1 latency
        bc0 = busy_cnt;
        start_op(MD_MULTU, 32'd5, 32'd1);
        wait_idle();
        check("eo_busy_cycles", 64'(busy_cnt - bc0), EO ? 64'd2 : 64'd33);
        check("eo_lo", {32'd0, lo}, 64'd5);

        // Large unsigned and signed products
        start_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_idle();
        check("big_hi", {32'd0, hi}, 64'h0000_0000_FFFF_FFFE);
        check("big_lo", {32'd0, lo}, 64'd1);
        start_op(MD_DIV, 32'd7, 32'hFFFF_FFFE);
        wait_idle();
        check("div_pos_neg_lo", {32'd0, lo}, 64'h0000_0000_FFFF_FFFD);
        check("div_pos_neg_hi", {32'd0, hi}, 64'd1);

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
